axil_reg_selftest_master: RTL
=============================

# axil_reg_selftest_master

AXI4-Lite master engine that sits directly upstream of the simple_reg AXI4-Lite slave register bank and exercises it in hardware. On a start pulse it writes an incrementing pattern to NUM_REGS consecutive 32-bit registers, reads each back, compares against the written value, and reports pass/fail and an error count. It provides the same write-then-readback check as the simulation bench, but synthesised on-chip for board bring-up.

## Interface
- C_M_AXI_ADDR_WIDTH, 32: AXI address width.
- C_M_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- NUM_REGS, 4: registers tested, 1..256.
- BASE_ADDR, 32'h0000_0000: address of register 0; register i is at BASE_ADDR + 4*i.
- SEED, 32'h0000_0001: value written to register 0; register i receives SEED + i (mod 2^32).
- TIMEOUT_CYCLES, 1024: maximum wait for any single handshake.

- ACLK  in  1  clock; everything is rising-edge.
- ARESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE is entered.
- done  out  1  high in DONE; stays high until the next accepted start or reset.
- pass  out  1  valid while done=1; 1 iff err_count==0 and no timeout.
- timeout  out  1  sticky; a handshake exceeded TIMEOUT_CYCLES.
- err_count  out  8  mismatches plus non-OKAY responses, saturating at 255.
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in: AW channel; AWPROT = 3'b000.
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in: W channel; WSTRB = 4'hF.
- M_AXI_BRESP/BVALID in, BREADY out.
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in: AR channel; ARPROT = 3'b000.
- M_AXI_RDATA/RRESP/RVALID in, RREADY out.

## Operation
- The engine is a single FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, and an index counter idx of width clog2(NUM_REGS+1).
- IDLE:
  - start=1 clears err_count, timeout and done, sets idx=0, and moves to WR_REQ.
- WR_REQ:
  - AWVALID and WVALID are asserted together, with AWADDR = BASE_ADDR+4*idx and WDATA = SEED+idx.
  - Each valid deasserts independently on its own handshake.
  - When both handshakes are complete, go to WR_RESP.
- WR_RESP:
  - BREADY=1. On BVALID, BRESP≠2'b00 increments err_count.
  - If idx==NUM_REGS-1, set idx=0 and go to RD_REQ; otherwise idx++ and go to WR_REQ.
- RD_REQ:
  - ARVALID=1 with ARADDR = BASE_ADDR+4*idx.
  - On ARREADY, go to RD_RESP.
- RD_RESP:
  - RREADY=1. On RVALID, err_count increments by 1 if RDATA≠SEED+idx or RRESP≠OKAY (at most +1 per beat).
  - If idx==NUM_REGS-1, go to DONE; otherwise idx++ and go to RD_REQ.
- DONE: done=1. start=1 restarts the sequence exactly as from IDLE.
- Timeout:
  - A per-state wait counter resets on every state entry.
  - If it reaches TIMEOUT_CYCLES in WR_REQ, WR_RESP, RD_REQ or RD_RESP, set timeout=1, drop all valid/ready outputs and go to DONE; pass=0.
- Arithmetic: address and data sums wrap modulo 2^width; err_count saturates at 255.

## Timing
- Reset values: all AXI valid/ready outputs 0, busy 0, done 0, pass 0, timeout 0, err_count 0; FSM in IDLE.
- ARESET asserted mid-transaction drops every valid in the next cycle. This is the only case where a valid drops without a handshake.
- start is accepted at edge N. AWVALID and WVALID are high from edge N+1.
- Valids are held stable, with constant addr/data, until their ready is sampled high.
- AWREADY and WREADY may arrive in either order or in the same cycle.
- BREADY and RREADY are high in their wait states even before the valid arrives. A response already valid on state entry is consumed in that first cycle.
- Minimum per register, with zero-wait slave: 2 cycles write (WR_REQ, WR_RESP) and 2 cycles read.
  - Total minimum for the sequence is 4*NUM_REGS cycles from accepted start to done.
- start received while busy is ignored.
- start and ARESET in the same cycle: reset wins.
- Only one outstanding transaction at a time; reads never overlap writes.

## Test plan
- Ideal slave (simple_reg, zero wait), defaults, start pulse:
  - writes 1,2,3,4 to 0x0,0x4,0x8,0xC, then reads back;
  - done after 16 cycles, pass=1, err_count=0.
- Slave with random AWREADY/WREADY skew (AW 3 cycles before W, then W 2 cycles before AW):
  - valids stay stable until their handshake;
  - exactly one transaction per register; pass=1.
- Slave forcing RDATA bit 0 flipped at register 2:
  - err_count=1, pass=0, done=1;
  - all 4 reads are still issued.
- Slave returning BRESP=SLVERR on every write, correct reads:
  - err_count=4, pass=0.
- AWREADY stuck low, TIMEOUT_CYCLES=16:
  - timeout=1 after 16 cycles in WR_REQ, AWVALID drops, done=1, pass=0.
- ARESET pulsed during RD_RESP of register 1, then a new start:
  - outputs return to reset values the next cycle;
  - the fresh run completes with pass=1.

Source files
------------

// File: rtl/axil_reg_selftest_master.sv
// AXI4-Lite self-test master: writes SEED+i to NUM_REGS consecutive registers, reads
// each back and reports mismatches, error responses and handshake timeouts.
module axil_reg_selftest_master #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter int                            NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = 32'h0000_0000,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0] SEED               = 32'h0000_0001,
    parameter int                            TIMEOUT_CYCLES     = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [7:0]                        err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int                IDX_W     = $clog2(NUM_REGS + 1);
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [7:0]          err_q, err_d;
    logic                timeout_q, timeout_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic                              err_inc;
    logic                              wait_expired;
    logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_cur;
    logic [C_M_AXI_DATA_WIDTH-1:0]     data_cur;

    assign addr_cur = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
    assign data_cur = SEED + C_M_AXI_DATA_WIDTH'(idx_q);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wait_q    <= wait_d;
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        err_d        = err_q;
        timeout_d    = timeout_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        wait_d       = wait_q + 1'b1;
        err_inc      = 1'b0;
        wait_expired = (wait_q == WAIT_LAST);

        case (state_q)
            S_IDLE, S_DONE: begin
                wait_d = '0;
                if (start) begin
                    state_d   = S_WR_REQ;
                    idx_d     = '0;
                    err_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_WR_REQ: begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done_d = 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_RESP;
                end else if (wait_expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    err_inc = (M_AXI_BRESP != 2'b00);
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_RD_REQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_WR_REQ;
                    end
                end else if (wait_expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_RD_RESP;
                end else if (wait_expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (M_AXI_RVALID) begin
                    err_inc = (M_AXI_RDATA != data_cur) || (M_AXI_RRESP != 2'b00);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_RD_REQ;
                    end
                end else if (wait_expired) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;

        // Wait counter and per-channel handshake flags restart on every state entry.
        if (state_d != state_q) begin
            wait_d    = '0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end
    end

    always_comb begin
        M_AXI_AWVALID = (state_q == S_WR_REQ) && !aw_done_q;
        M_AXI_WVALID  = (state_q == S_WR_REQ) && !w_done_q;
        M_AXI_BREADY  = (state_q == S_WR_RESP);
        M_AXI_ARVALID = (state_q == S_RD_REQ);
        M_AXI_RREADY  = (state_q == S_RD_RESP);
        busy          = state_q inside {S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP};
        done          = (state_q == S_DONE);
        pass          = done && (err_q == 8'd0) && !timeout_q;
    end

    assign M_AXI_AWADDR = addr_cur;
    assign M_AXI_ARADDR = addr_cur;
    assign M_AXI_WDATA  = data_cur;
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign timeout      = timeout_q;
    assign err_count    = err_q;

endmodule
